// File: rtl/lstm_acc_pkg.sv
// Shared definitions for the LSTM accelerator load path.
//   - Default main_mem geometry (word width, address width).
//   - Load image layout: input words first, then weight bank W1, then W2.
//   - Region and loader FSM state encodings.
package lstm_acc_pkg;

    localparam int ELEMENT_BITS     = 8;
    localparam int MAIN_MEM_ADD_LEN = 11;
    localparam int INPUT_SIZE       = 40;
    localparam int WEIGHTS          = 64;

    // Contiguous load image: IN | W1 | W2
    localparam int IN_BASE     = 0;
    localparam int W1_BASE     = IN_BASE + INPUT_SIZE;
    localparam int W2_BASE     = W1_BASE + WEIGHTS;
    localparam int TOTAL_WORDS = W2_BASE + WEIGHTS;

    typedef enum logic [1:0] {
        REGION_IN   = 2'd0,
        REGION_W1   = 2'd1,
        REGION_W2   = 2'd2,
        REGION_NONE = 2'd3
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GAP  = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_loader.sv
// mem_loader: streams the input vector and both weight banks into main_mem,
// waits a settle interval, then raises start to wake the accelerator.
//
// Ports:
//   fpga_clk    in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   arm         in   pulse; begins a new load (honoured in IDLE and RUN)
//   in_valid    in   upstream word valid
//   in_data     in   upstream word
//   in_ready    out  loader accepts a word this cycle (high in LOAD)
//   wr_we       out  main_mem write enable, registered
//   wr_address  out  main_mem write address, registered
//   wr_data     out  main_mem write data, registered
//   region      out  region of the next accepted word (IN/W1/W2, 3 = none)
//   start       out  level wake-up to the accelerator, registered
//   busy        out  high while loading or settling
module mem_loader #(
    parameter int ELEMENT_BITS     = lstm_acc_pkg::ELEMENT_BITS,
    parameter int MAIN_MEM_ADD_LEN = lstm_acc_pkg::MAIN_MEM_ADD_LEN,
    parameter int INPUT_SIZE       = lstm_acc_pkg::INPUT_SIZE,
    parameter int WEIGHTS          = lstm_acc_pkg::WEIGHTS,
    parameter int START_DELAY      = 50
) (
    input  logic                        fpga_clk,
    input  logic                        reset_n,
    input  logic                        arm,
    input  logic                        in_valid,
    input  logic [ELEMENT_BITS-1:0]     in_data,
    output logic                        in_ready,
    output logic                        wr_we,
    output logic [MAIN_MEM_ADD_LEN-1:0] wr_address,
    output logic [ELEMENT_BITS-1:0]     wr_data,
    output logic [1:0]                  region,
    output logic                        start,
    output logic                        busy
);

    import lstm_acc_pkg::*;

    localparam int AW          = MAIN_MEM_ADD_LEN;
    localparam int W1_START    = INPUT_SIZE;
    localparam int W2_START    = INPUT_SIZE + WEIGHTS;
    localparam int LOAD_WORDS  = INPUT_SIZE + 2 * WEIGHTS;
    localparam int CNT_W       = (START_DELAY < 2) ? 1 : $clog2(START_DELAY + 1);

    // The whole image must be addressable by the write port.
    if (LOAD_WORDS > (1 << MAIN_MEM_ADD_LEN)) begin : g_size_check
        $error("mem_loader: INPUT_SIZE + 2*WEIGHTS exceeds main_mem address space");
    end

    if (START_DELAY < 0) begin : g_delay_check
        $error("mem_loader: START_DELAY must be non-negative");
    end

    state_e           state;
    state_e           state_next;
    logic [AW-1:0]    ptr;
    logic [CNT_W-1:0] gap_cnt;
    logic             accept;
    logic             last_beat;
    logic             gap_done;
    region_e          region_c;

    assign in_ready  = (state == ST_LOAD);
    assign busy      = (state == ST_LOAD) || (state == ST_GAP);
    assign accept    = in_ready && in_valid;
    assign last_beat = accept && (ptr == AW'(LOAD_WORDS - 1));
    // GAP lasts START_DELAY counting edges plus the edge that leaves it, so
    // START_DELAY=0 still spends exactly one cycle in GAP.
    assign gap_done  = (state == ST_GAP) && (gap_cnt == CNT_W'(START_DELAY));

    // NOTE: every variable written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (arm)       state_next = ST_LOAD;
            ST_LOAD: if (last_beat) state_next = ST_GAP;
            ST_GAP:  if (gap_done)  state_next = ST_RUN;
            ST_RUN:  if (arm)       state_next = ST_LOAD;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        region_c = REGION_NONE;
        if (state == ST_LOAD) begin
            if (ptr < AW'(W1_START)) begin
                region_c = REGION_IN;
            end else if (ptr < AW'(W2_START)) begin
                region_c = REGION_W1;
            end else begin
                region_c = REGION_W2;
            end
        end
    end

    assign region = region_c;

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the pre-edge values regardless of statement order.
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= '0;
            gap_cnt    <= '0;
            wr_we      <= 1'b0;
            wr_address <= '0;
            wr_data    <= '0;
            start      <= 1'b0;
        end else begin
            // Reset clears wr_we asynchronously, which also kills a write that
            // was accepted on the previous edge but not yet consumed.
            wr_we <= accept;
            if (accept) begin
                wr_address <= ptr;
                wr_data    <= in_data;
            end

            // Every entry into LOAD (from IDLE or RUN) restarts at address 0.
            if ((state_next == ST_LOAD) && (state != ST_LOAD)) begin
                ptr <= '0;
            end else if (accept) begin
                ptr <= ptr + AW'(1);
            end

            if ((state == ST_GAP) && !gap_done) begin
                gap_cnt <= gap_cnt + CNT_W'(1);
            end else begin
                gap_cnt <= '0;
            end

            // Registered from next state: rises on the edge entering RUN and
            // falls on the same edge that an arm in RUN re-enters LOAD.
            start <= (state_next == ST_RUN);
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed testbench for mem_loader with the default parameter set
// (168-word image, 50-cycle settle). Outputs are sampled 1 ns after the
// rising edge; a negedge monitor records every main_mem write.
`timescale 1ns/1ps
module tb_mem_loader;

    localparam int AW    = 11;
    localparam int TOTAL = 168;

    logic          fpga_clk = 1'b0;
    logic          reset_n  = 1'b0;
    logic          arm      = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data  = 8'h00;
    logic          in_ready;
    logic          wr_we;
    logic [AW-1:0] wr_address;
    logic [7:0]    wr_data;
    logic [1:0]    region;
    logic          start;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [AW-1:0] wa_q[$];
    logic [7:0]    wd_q[$];
    int            wc_q[$];

    mem_loader dut (
        .fpga_clk   (fpga_clk),
        .reset_n    (reset_n),
        .arm        (arm),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_we      (wr_we),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .region     (region),
        .start      (start),
        .busy       (busy)
    );

    always #5 fpga_clk = ~fpga_clk;

    always @(posedge fpga_clk) cyc = cyc + 1;

    always @(negedge fpga_clk) begin
        if (wr_we !== 1'b0) begin
            wa_q.push_back(wr_address);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
    end

    function automatic logic [7:0] pat(input int sel, input int k);
        logic [7:0] kb;
        kb = k[7:0];
        case (sel)
            0:       return kb;
            1:       return kb ^ 8'h5A;
            default: return kb * 8'd7 + 8'd3;
        endcase
    endfunction

    function automatic logic [1:0] exp_region(input int k);
        if (k < 40)  return 2'd0;
        if (k < 104) return 2'd1;
        return 2'd2;
    endfunction

    task automatic tick();
        @(posedge fpga_clk);
        #1;
    endtask

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    // One-cycle arm pulse; returns 1 ns after the edge that consumed it.
    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Drives n beats with pattern sel; bubbles gives ~50% valid duty.
    // arm_at >= 0 raises arm together with that beat.
    task automatic send_stream(input int n, input int sel, input bit bubbles, input int arm_at);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 4000) begin
            in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = pat(sel, k);
            arm      = (k == arm_at) && in_valid;
            tick();
            if (in_valid) k++;
            guard++;
        end
        in_valid = 1'b0;
        arm      = 1'b0;
    endtask

    // Edges from the current point until start is seen high (bounded).
    task automatic wait_start(output int edges);
        edges = 0;
        while (start !== 1'b1 && edges < 300) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (wr_we !== 1'b0)        begin n_fail++; $display("FAIL rst_wr_we got %b want 0", wr_we); end
        n_checks++; if (wr_address !== '0)     begin n_fail++; $display("FAIL rst_wr_address got %0d want 0", wr_address); end
        n_checks++; if (wr_data !== 8'h00)     begin n_fail++; $display("FAIL rst_wr_data got %h want 00", wr_data); end
        n_checks++; if (start !== 1'b0)        begin n_fail++; $display("FAIL rst_start got %b want 0", start); end
        n_checks++; if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_checks++; if (region !== 2'd3)       begin n_fail++; $display("FAIL rst_region got %0d want 3", region); end
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        // in_valid in IDLE must be ignored
        clear_writes();
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (5) tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL idle_in_ready got %b want 0", in_ready); end
        n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
        tick();
        n_checks++; if (wa_q.size() != 0)      begin n_fail++; $display("FAIL idle_writes got %0d want 0", wa_q.size()); end
    endtask

    task automatic test_full_load();
        int edges;
        clear_writes();
        pulse_arm();
        n_checks++; if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL full_arm_in_ready got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b1)         begin n_fail++; $display("FAIL full_arm_busy got %b want 1", busy); end
        for (int k = 0; k < TOTAL; k++) begin
            in_valid = 1'b1;
            in_data  = pat(0, k);
            n_checks++; if (region !== exp_region(k)) begin n_fail++; $display("FAIL full_region beat %0d got %0d want %0d", k, region, exp_region(k)); end
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_in_ready beat %0d got %b want 1", k, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (region !== 2'd3)       begin n_fail++; $display("FAIL gap_region got %0d want 3", region); end
        n_checks++; if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL gap_in_ready got %b want 0", in_ready); end
        n_checks++; if (busy !== 1'b1)         begin n_fail++; $display("FAIL gap_busy got %b want 1", busy); end
        n_checks++; if (start !== 1'b0)        begin n_fail++; $display("FAIL gap_start got %b want 0", start); end
        // arm pulsed during GAP must not disturb the settle count
        edges = 0;
        while (start !== 1'b1 && edges < 300) begin
            arm = (edges == 10);
            tick();
            edges++;
        end
        arm = 1'b0;
        n_checks++; if (edges != 51)           begin n_fail++; $display("FAIL full_start_delay got %0d edges want 51", edges); end
        n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL run_busy got %b want 0", busy); end
        n_checks++; if (wa_q.size() != TOTAL)  begin n_fail++; $display("FAIL full_write_count got %0d want %0d", wa_q.size(), TOTAL); end
        for (int i = 0; i < wa_q.size(); i++) begin
            n_checks++; if (wa_q[i] !== AW'(i)) begin n_fail++; $display("FAIL full_addr idx %0d got %0d want %0d", i, wa_q[i], i); end
            n_checks++; if (wd_q[i] !== pat(0, i)) begin n_fail++; $display("FAIL full_data idx %0d got %h want %h", i, wd_q[i], pat(0, i)); end
            n_checks++; if (wc_q[i] != wc_q[0] + i) begin n_fail++; $display("FAIL full_cadence idx %0d got cycle %0d want %0d", i, wc_q[i], wc_q[0] + i); end
        end
    endtask

    task automatic test_run_ignore();
        clear_writes();
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (5) begin
            tick();
            n_checks++; if (start !== 1'b1)    begin n_fail++; $display("FAIL run_start got %b want 1", start); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL run_in_ready got %b want 0", in_ready); end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (wa_q.size() != 0)      begin n_fail++; $display("FAIL run_writes got %0d want 0", wa_q.size()); end
    endtask

    task automatic test_arm_in_run();
        int edges;
        clear_writes();
        pulse_arm();
        n_checks++; if (start !== 1'b0)        begin n_fail++; $display("FAIL rearm_start got %b want 0", start); end
        n_checks++; if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL rearm_in_ready got %b want 1", in_ready); end
        n_checks++; if (region !== 2'd0)       begin n_fail++; $display("FAIL rearm_region got %0d want 0", region); end
        // arm raised together with beat 20 must not move the pointer
        send_stream(TOTAL, 1, 1'b0, 20);
        wait_start(edges);
        n_checks++; if (edges != 51)           begin n_fail++; $display("FAIL rearm_start_delay got %0d edges want 51", edges); end
        n_checks++; if (wa_q.size() != TOTAL)  begin n_fail++; $display("FAIL rearm_write_count got %0d want %0d", wa_q.size(), TOTAL); end
        for (int i = 0; i < wa_q.size(); i++) begin
            n_checks++; if (wa_q[i] !== AW'(i)) begin n_fail++; $display("FAIL rearm_addr idx %0d got %0d want %0d", i, wa_q[i], i); end
            n_checks++; if (wd_q[i] !== pat(1, i)) begin n_fail++; $display("FAIL rearm_data idx %0d got %h want %h", i, wd_q[i], pat(1, i)); end
        end
    endtask

    task automatic test_bubbles();
        int edges;
        clear_writes();
        pulse_arm();
        send_stream(TOTAL, 2, 1'b1, -1);
        wait_start(edges);
        n_checks++; if (edges != 51)           begin n_fail++; $display("FAIL bub_start_delay got %0d edges want 51", edges); end
        n_checks++; if (wa_q.size() != TOTAL)  begin n_fail++; $display("FAIL bub_write_count got %0d want %0d", wa_q.size(), TOTAL); end
        for (int i = 0; i < wa_q.size(); i++) begin
            n_checks++; if (wa_q[i] !== AW'(i)) begin n_fail++; $display("FAIL bub_addr idx %0d got %0d want %0d", i, wa_q[i], i); end
            n_checks++; if (wd_q[i] !== pat(2, i)) begin n_fail++; $display("FAIL bub_data idx %0d got %h want %h", i, wd_q[i], pat(2, i)); end
        end
    endtask

    task automatic test_reset_mid_load();
        int edges;
        clear_writes();
        pulse_arm();
        send_stream(71, 0, 1'b0, -1);
        // beat 70 was just accepted; its write is still pending
        reset_n = 1'b0;
        #1;
        n_checks++; if (wr_we !== 1'b0)        begin n_fail++; $display("FAIL mid_rst_wr_we got %b want 0", wr_we); end
        n_checks++; if (wr_address !== '0)     begin n_fail++; $display("FAIL mid_rst_wr_address got %0d want 0", wr_address); end
        n_checks++; if (wr_data !== 8'h00)     begin n_fail++; $display("FAIL mid_rst_wr_data got %h want 00", wr_data); end
        n_checks++; if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_in_ready got %b want 0", in_ready); end
        n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        n_checks++; if (region !== 2'd3)       begin n_fail++; $display("FAIL mid_rst_region got %0d want 3", region); end
        n_checks++; if (start !== 1'b0)        begin n_fail++; $display("FAIL mid_rst_start got %b want 0", start); end
        repeat (3) tick();
        n_checks++; if (wa_q.size() != 70)     begin n_fail++; $display("FAIL mid_rst_write_count got %0d want 70", wa_q.size()); end
        for (int i = 0; i < wa_q.size(); i++) begin
            n_checks++; if (wa_q[i] !== AW'(i)) begin n_fail++; $display("FAIL mid_rst_addr idx %0d got %0d want %0d", i, wa_q[i], i); end
        end
        reset_n = 1'b1;
        tick();
        clear_writes();
        pulse_arm();
        send_stream(TOTAL, 0, 1'b0, -1);
        wait_start(edges);
        n_checks++; if (edges != 51)           begin n_fail++; $display("FAIL reload_start_delay got %0d edges want 51", edges); end
        n_checks++; if (wa_q.size() != TOTAL)  begin n_fail++; $display("FAIL reload_write_count got %0d want %0d", wa_q.size(), TOTAL); end
        for (int i = 0; i < wa_q.size(); i++) begin
            n_checks++; if (wa_q[i] !== AW'(i)) begin n_fail++; $display("FAIL reload_addr idx %0d got %0d want %0d", i, wa_q[i], i); end
            n_checks++; if (wd_q[i] !== pat(0, i)) begin n_fail++; $display("FAIL reload_data idx %0d got %h want %h", i, wd_q[i], pat(0, i)); end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_run_ignore();
        test_arm_in_run();
        test_bubbles();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter ELEMENT_BITS, 8, width of one main_mem word.
REQ-002 Parameter MAIN_MEM_ADD_LEN, 11, main_mem address width.
REQ-003 Parameter INPUT_SIZE, 40, input words (FEATURES*CYCLES) loaded first at address 0.
REQ-004 Parameter WEIGHTS, 64, words per weight bank (W1, then W2).
REQ-005 Parameter START_DELAY, 50, settle cycles between final write and start.
REQ-006 Port fpga_clk  in  1  single system clock; all state changes on its rising edge.
REQ-007 Port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-008 Port arm  in  1  pulse; begin a new load sequence.
REQ-009 Port in_valid  in  1  upstream word valid.
REQ-010 Port in_data  in  ELEMENT_BITS  upstream word.
REQ-011 Port in_ready  out  1  loader accepts a word this cycle.
REQ-012 Port wr_we  out  1  main_mem write-port chip-select/write-enable.
REQ-013 Port wr_address  out  MAIN_MEM_ADD_LEN  main_mem write address.
REQ-014 Port wr_data  out  ELEMENT_BITS  main_mem write data.
REQ-015 Port region  out  2  region of the next accepted word: 0=IN, 1=W1, 2=W2, 3=none.
REQ-016 Port start  out  1  level; system wake-up to the accelerator top.
REQ-017 Port busy  out  1  high in LOAD or GAP.

Function
REQ-018 The block SHALL be an FSM with states IDLE, LOAD, GAP, RUN.
REQ-019 IDLE: in_ready=0, start=0; arm -> LOAD with word pointer cleared to 0.
REQ-020 LOAD: in_ready=1 combinationally from state; a beat is accepted on a rising edge with in_valid&&in_ready.
REQ-021 Accepted beat k (0-based) SHALL produce, one cycle later, wr_we=1 for exactly one cycle, wr_address=k, wr_data=that beat's in_data.
REQ-022 Address map SHALL be contiguous: IN at 0..INPUT_SIZE-1, W1 at INPUT_SIZE..INPUT_SIZE+WEIGHTS-1, W2 following; TOTAL=INPUT_SIZE+2*WEIGHTS (168 by default).
REQ-023 region SHALL reflect the pointer in LOAD and read 3 in every other state.
REQ-024 in_valid=0 in LOAD SHALL stall with no write and no pointer change; bubbles of any length are legal.
REQ-025 Acceptance of beat TOTAL-1 SHALL move the FSM to GAP on that edge; in_ready is 0 from the next cycle.
REQ-026 GAP SHALL count START_DELAY cycles, then enter RUN; START_DELAY=0 enters RUN the edge after entering GAP.
REQ-027 RUN: start=1 held, in_ready=0, no writes; stays until arm or reset.
REQ-028 arm in RUN SHALL drop start on the same edge and enter LOAD with pointer 0.
REQ-029 arm in LOAD or GAP SHALL be ignored.
REQ-030 in_valid outside LOAD SHALL be ignored and produce no write.
REQ-031 Pointer arithmetic SHALL be MAIN_MEM_ADD_LEN bits; TOTAL must not exceed 2**MAIN_MEM_ADD_LEN, checked by an elaboration-time assertion.
REQ-032 All outputs except in_ready, region and busy SHALL be registered.

Reset
REQ-033 reset_n low SHALL asynchronously force IDLE, pointer=0, GAP counter=0, wr_we=0, wr_address=0, wr_data=0, start=0, in_ready=0, busy=0, region=3.
REQ-034 Reset mid-LOAD SHALL abandon the sequence; no write is issued after reset asserts, including the pending one-cycle-delayed write.

Structure
REQ-035 ELEMENT_BITS, MAIN_MEM_ADD_LEN, INPUT_SIZE, WEIGHTS, region base addresses and the region and FSM-state enums SHALL live in shared package lstm_acc_pkg.
REQ-036 The block SHALL be one flat module; no sub-module is warranted.

Verification
REQ-037 Full load, in_valid always high, data=k[7:0]: writes at addresses 0..167 with data 0..167, one per cycle; start rises 51 edges after the final beat is accepted.
REQ-038 Region boundaries: region reads 0 for beats 0..39, 1 for beats 40..103, 2 for beats 104..167, 3 in GAP.
REQ-039 Random valid bubbles (50% duty) across the full load: 168 writes, no duplicate or skipped address, data matches stream order.
REQ-040 reset_n low after beat 70 is accepted: no further wr_we, all outputs at reset values; arm after reset, then 168 beats, completes normally from address 0.
REQ-041 arm in RUN: start falls on the same edge, in_ready=1 next cycle, the next write targets address 0.
REQ-042 arm pulsed mid-LOAD and in_valid driven in IDLE and RUN: pointer unaffected, no spurious writes.
